out_port_fifo: RTL and testbench
================================

// Module: out_port_fifo
// PURPOSE
// - Parametrised successor to the single 8-bit display register: buffers controller DISPLAY strobes of alu_out
//   into a FIFO and drains them to CHANNELS latched output ports over a valid/ready interface.
// - Sits between the controller/ALU (write side) and the chip output pins or off-chip monitor (read side).
// - Asserts stall when full so the controller can freeze instead of losing a value.
// PARAMETERS
// - DATA_W    8  width of one output value (alu_out width)
// - DEPTH     4  FIFO entries; power of two, >= 2
// - CHANNELS  2  number of latched output ports; >= 2
// - CH_W      derived localparam = $clog2(CHANNELS); not overridable
// PORTS
// - clk        in   1                 single clock, all state on rising edge
// - rst_n      in   1                 reset, asynchronous, active-low
// - wr_en      in   1                 display strobe from controller
// - wr_ch      in   CH_W              target channel for this write
// - wr_data    in   DATA_W            value to output (alu_out)
// - stall      out  1                 FIFO full; controller must hold wr_en/ch/data
// - out_valid  out  1                 head entry available
// - out_ready  in   1                 consumer accepts head entry this cycle
// - out_ch     out  CH_W              channel of head entry
// - out_data   out  DATA_W            data of head entry
// - port_q     out  CHANNELS*DATA_W   last drained value per channel; ch k at [k*DATA_W +: DATA_W]
// - ovf        out  1                 sticky: a write was dropped
// - ovf_clr    in   1                 clears ovf (sync)
// BEHAVIOUR
// - Reset (rst_n low, async): rd/wr ptr=0, count=0, stall=0, out_valid=0, out_ch=0, out_data=0, port_q=0, ovf=0.
//   Reset mid-operation discards all entries; out_valid drops immediately, not at next edge.
// - Entry = {ch, data}; storage DEPTH x (CH_W+DATA_W). count width $clog2(DEPTH)+1.
// - push = wr_en & (wr_ch < CHANNELS) & (count < DEPTH | pop); pop = out_valid & out_ready.
// - Out-of-range wr_ch: write ignored, no count change, ovf unaffected.
// - Full (count==DEPTH): stall=1; push only allowed if pop same cycle (count stays DEPTH).
// - wr_en while full and no pop: write dropped, ovf<=1. ovf_clr and a new drop same cycle -> ovf stays 1.
// - Latency: write accepted at edge N -> out_valid/out_data visible after edge N (cycle N+1). No bypass;
//   push into empty FIFO with out_ready=1 still takes one cycle.
// - out_valid = (count!=0); out_ch/out_data = head entry, combinational from storage; undefined-free (0) when empty.
// - Handshake: head entry stable while out_valid & !out_ready. pop when empty impossible (out_valid=0).
// - On pop: port_q[out_ch] <= out_data; other channels hold. rd_ptr increments.
// - Simultaneous push & pop: count unchanged; both pointers advance.
// - Pointers wrap modulo DEPTH (natural overflow of $clog2(DEPTH)-bit pointer).
// - stall = (count==DEPTH), registered-state derived, no combinational path from out_ready.
// - Strict FIFO order across channels; no per-channel reordering.
// STRUCTURE
// - Shared package/header sap3_pkg: OUT_DATA_W=8, OUT_CHANNELS, OUT_FIFO_DEPTH defaults, entry-width macro.
// - One sub-module: sync_fifo (DEPTH, WIDTH; push/pop/full/empty/count, async active-low reset).
//   out_port_fifo = sync_fifo + channel decode + port_q registers + ovf flag.
// TESTING
// - Reset: drive wr_en=1 during rst_n=0 -> all outputs 0, no entry stored after release.
// - Single write ch1 data 0x5A, out_ready=1 -> out_valid high 1 cycle later, out_ch=1, out_data=0x5A;
//   next edge port_q[ch1]=0x5A, port_q[ch0]=0x00, out_valid=0.
// - Fill: out_ready=0, write 0x01..0x04 (DEPTH=4) -> stall=1 after 4th; 5th write 0x05 dropped, ovf=1;
//   then drain -> data 0x01,0x02,0x03,0x04 in order, stall=0 after first pop.
// - Full with concurrent push/pop: full, out_ready=1 and wr_en=1 data 0x77 -> count stays 4, ovf unchanged,
//   0x77 emerges last.
// - Backpressure: out_ready toggled 1/0 every cycle across 8 writes to alternating ch0/ch1 -> no loss, no
//   duplication, head stable while not ready, final port_q = last value per channel.
// - Reset mid-drain with 3 entries queued -> out_valid falls without clock edge; port_q cleared to 0.

Source files
------------

// File: rtl/sap3_pkg.sv
// Shared defaults for the output-port path: value width, channel count, FIFO depth,
// and the width of one buffered {channel, data} entry.
package sap3_pkg;

    localparam int OUT_DATA_W     = 8;
    localparam int OUT_CHANNELS   = 2;
    localparam int OUT_FIFO_DEPTH = 4;

    function automatic int out_entry_w(input int ch_w, input int data_w);
        return ch_w + data_w;
    endfunction

endpackage

// File: rtl/out_port_fifo_sync_fifo.sv
// Generic synchronous FIFO. Pointers wrap naturally; the caller is responsible
// for never pushing when full unless it pops in the same cycle.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: the head is only observed while count is non-zero.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/out_port_fifo.sv
// Buffers display strobes as {channel, data} entries and drains them in order to
// per-channel latched output ports over a valid/ready handshake.
module out_port_fifo
    import sap3_pkg::*;
#(
    parameter int DATA_W   = OUT_DATA_W,
    parameter int DEPTH    = OUT_FIFO_DEPTH,
    parameter int CHANNELS = OUT_CHANNELS
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          wr_en,
    input  logic [$clog2(CHANNELS)-1:0]   wr_ch,
    input  logic [DATA_W-1:0]             wr_data,
    output logic                          stall,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(CHANNELS)-1:0]   out_ch,
    output logic [DATA_W-1:0]             out_data,
    output logic [CHANNELS*DATA_W-1:0]    port_q,
    output logic                          ovf,
    input  logic                          ovf_clr
);

    localparam int CH_W  = $clog2(CHANNELS);
    localparam int ENT_W = out_entry_w(CH_W, DATA_W);

    logic                  ch_ok, push, pop, drop;
    logic                  full, empty;
    logic [ENT_W-1:0]      head;
    logic [$clog2(DEPTH):0] count;

    logic [CHANNELS-1:0][DATA_W-1:0] port_q_q;
    logic                            ovf_q, ovf_d;

    assign ch_ok = (32'(wr_ch) < CHANNELS);
    assign pop   = out_valid & out_ready;
    assign push  = wr_en & ch_ok & (!full | pop);
    assign drop  = wr_en & ch_ok & full & !pop;

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({wr_ch, wr_data}),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Mask the head so nothing stale leaks onto the outputs while empty.
    assign out_valid          = !empty;
    assign {out_ch, out_data} = empty ? '0 : head;
    assign stall              = full;

    // A fresh drop wins over a clear in the same cycle.
    assign ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            port_q_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (pop) port_q_q[out_ch] <= out_data;
            ovf_q <= ovf_d;
        end
    end

    assign port_q = port_q_q;
    assign ovf    = ovf_q;

endmodule

// File: tb/tb_out_port_fifo.sv
// Directed bench for out_port_fifo (DATA_W=8, DEPTH=4, CHANNELS=2).
module tb_out_port_fifo;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [0:0]  wr_ch;
    logic [7:0]  wr_data;
    logic        stall;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [7:0]  out_data;
    logic [15:0] port_q;
    logic        ovf;
    logic        ovf_clr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    out_port_fifo #(.DATA_W(8), .DEPTH(4), .CHANNELS(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (wr_en),
        .wr_ch     (wr_ch),
        .wr_data   (wr_data),
        .stall     (stall),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .port_q    (port_q),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [0:0] ch, input logic [7:0] d);
        wr_en = 1'b1; wr_ch = ch; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    logic [8:0] exp_q[$];
    logic [7:0] last_val [2];
    logic [8:0] prev_head;
    logic       prev_hold;
    int         nwr;
    logic [7:0] drain_exp [4];

    initial begin
        rst_n = 1'b0; wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'hAA;
        out_ready = 1'b0; ovf_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ch",    out_ch, 0);
        chk("rst_data",  out_data, 0);
        chk("rst_port",  port_q, 0);
        chk("rst_ovf",   ovf, 0);
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_valid", out_valid, 0);

        // single write, no bypass
        out_ready = 1'b1;
        wr_en = 1'b1; wr_ch = 1'b1; wr_data = 8'h5A;
        #1 chk("nobypass_valid", out_valid, 0);
        @(negedge clk);
        wr_en = 1'b0;
        chk("single_valid", out_valid, 1);
        chk("single_ch",    out_ch, 1);
        chk("single_data",  out_data, 8'h5A);
        @(negedge clk);
        chk("single_port",  port_q, 16'h5A00);
        chk("single_empty", out_valid, 0);

        // fill, overflow, ovf clear priority
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) wr(1'b0, 8'(i));
        chk("fill_stall", stall, 1);
        wr(1'b0, 8'h05);
        chk("drop_ovf", ovf, 1);
        chk("drop_stall", stall, 1);
        ovf_clr = 1'b1;
        wr(1'b0, 8'h06);
        chk("clr_vs_drop_ovf", ovf, 1);
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("clr_ovf", ovf, 0);

        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk($sformatf("drain_%0d", i), out_data, 8'(i));
            @(negedge clk);
            if (i == 1) chk("drain_stall", stall, 0);
        end
        chk("drain_empty", out_valid, 0);
        chk("drain_port", port_q, 16'h5A04);

        // concurrent push/pop at full
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) wr(1'b1, 8'h10 + 8'(i));
        out_ready = 1'b1;
        wr(1'b1, 8'h77);
        out_ready = 1'b0;
        chk("pp_stall", stall, 1);
        chk("pp_ovf", ovf, 0);
        chk("pp_head", out_data, 8'h11);
        drain_exp = '{8'h11, 8'h12, 8'h13, 8'h77};
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pp_drain_%0d", i), out_data, drain_exp[i]);
            @(negedge clk);
        end
        chk("pp_empty", out_valid, 0);
        chk("pp_port", port_q, 16'h7704);

        // backpressure with a scoreboard
        nwr = 0; prev_hold = 1'b0; prev_head = '0;
        last_val[0] = 8'h04; last_val[1] = 8'h77;
        for (int cyc = 0; cyc < 60 && (nwr < 8 || exp_q.size() != 0); cyc++) begin
            out_ready = cyc[0];
            wr_en = (nwr < 8);
            wr_ch = 1'(nwr); wr_data = 8'h80 + 8'(nwr);
            #1;
            if (prev_hold) chk("bp_head_stable", {out_ch, out_data}, prev_head);
            chk("bp_valid", out_valid, exp_q.size() != 0);
            if (out_valid && out_ready && exp_q.size() != 0) begin
                chk("bp_head", {out_ch, out_data}, exp_q[0]);
                last_val[exp_q[0][8]] = exp_q[0][7:0];
                void'(exp_q.pop_front());
            end
            if (wr_en && (exp_q.size() < 4 || (out_valid && out_ready))) begin
                exp_q.push_back({wr_ch, wr_data});
                nwr++;
            end
            prev_hold = out_valid && !out_ready;
            prev_head = {out_ch, out_data};
            @(negedge clk);
        end
        wr_en = 1'b0;
        chk("bp_done", (nwr == 8 && exp_q.size() == 0), 1);
        chk("bp_port", port_q, {last_val[1], last_val[0]});

        // reset mid-drain
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) wr(1'(i), 8'hC0 + 8'(i));
        chk("mid_valid_pre", out_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_valid_async", out_valid, 0);
        chk("mid_port", port_q, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_after", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
